// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch channel between the IF stage (master) and instruction memory (slave).
// Once imem_req is high, imem_addr stays stable until imem_ack. imem_rdata is valid in the ack cycle.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// IF stage: owns the PC, fetches over req/ack, and fills IF/ID. With 0-wait memory and no stall, one instruction per cycle.
// A stall parks an acked word in a hold buffer. A redirect squashes the IF/ID entry, and the wrong-path fetch drains.
module if_fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   PCWrite,
  input  logic                   IFID_Write,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
  input  logic                   jump,
  input  logic [31:0]            jump_target,
  if_fetch_stage_if.master       imem,
  output logic [31:0]            IF_ID_instr,
  output logic [31:0]            IF_ID_PCplus4,
  output logic                   IF_ID_valid
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] hold_q;
  logic [31:0] pend_q;
  logic [31:0] instr_q;
  logic [31:0] pcplus4_q;
  logic        valid_q;

  logic        stall;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // Jumps come from ID and are lost while ID is stalled; a branch from EX/MEM always wins.
  assign stall    = !PCWrite || !IFID_Write;
  assign redirect = branch_taken || (jump && !stall);
  assign target   = branch_taken ? branch_target : jump_target;
  assign pc_plus4 = pc_q + 32'd4;

  assign imem.imem_req  = !reset && (state_q != S_HOLD);
  assign imem.imem_addr = pc_q;

  assign IF_ID_instr   = instr_q;
  assign IF_ID_PCplus4 = pcplus4_q;
  assign IF_ID_valid   = valid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_REQ;
      pc_q      <= PC_RESET;
      hold_q    <= '0;
      pend_q    <= '0;
      instr_q   <= NOP_INSTR;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem.imem_ack) begin
            if (redirect) begin
              pc_q    <= target;
              instr_q <= NOP_INSTR;
              valid_q <= 1'b0;
            end else if (!stall) begin
              instr_q   <= imem.imem_rdata;
              pcplus4_q <= pc_plus4;
              valid_q   <= 1'b1;
              pc_q      <= pc_plus4;
            end else begin
              hold_q  <= imem.imem_rdata;
              state_q <= S_HOLD;
            end
          end else if (redirect) begin
            // The request cannot be withdrawn, so remember where to go once it completes.
            pend_q  <= target;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            state_q <= S_DRAIN;
          end else if (!stall) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
          end
        end

        S_HOLD: begin
          if (redirect) begin
            pc_q    <= target;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            state_q <= S_REQ;
          end else if (!stall) begin
            instr_q   <= hold_q;
            pcplus4_q <= pc_plus4;
            valid_q   <= 1'b1;
            pc_q      <= pc_plus4;
            state_q   <= S_REQ;
          end
        end

        S_DRAIN: begin
          instr_q <= NOP_INSTR;
          valid_q <= 1'b0;
          if (redirect) begin
            pend_q <= target;
          end
          if (imem.imem_ack) begin
            pc_q    <= redirect ? target : pend_q;
            state_q <= S_REQ;
          end
        end

        default: state_q <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage. Memory returns addr+ofs, and the ack is gated by ack_en.
// A scoreboard checks every IF/ID write that happens without a stall.
module tb_if_fetch_stage;
  logic        clock;
  logic        reset;
  logic        PCWrite;
  logic        IFID_Write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_PCplus4;
  logic        IF_ID_valid;
  logic        ack_en;
  logic [31:0] ofs;

  if_fetch_stage_if mem ();
  assign mem.imem_ack   = mem.imem_req & ack_en;
  assign mem.imem_rdata = mem.imem_addr + ofs;

  if_fetch_stage dut (
    .clock(clock), .reset(reset), .PCWrite(PCWrite), .IFID_Write(IFID_Write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .imem(mem),
    .IF_ID_instr(IF_ID_instr), .IF_ID_PCplus4(IF_ID_PCplus4), .IF_ID_valid(IF_ID_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { logic [31:0] instr; logic [31:0] pc4; } exp_t;
  typedef struct { bit jp; logic [31:0] tgt; logic [31:0] ofs; int n; logic [31:0] next; } vec_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic        prev_nostall = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // An IF/ID write without a stall either carries the next expected word or is a bubble.
  always @(posedge clock) prev_nostall <= !reset && PCWrite && IFID_Write;

  always @(negedge clock) begin
    if (prev_nostall) begin
      if (IF_ID_valid) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_instr", IF_ID_instr, 32'hxxxx_xxxx);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ifid_instr", IF_ID_instr, e.instr);
          chk("ifid_pc4", IF_ID_PCplus4, e.pc4);
        end
      end else begin
        chk("bubble_nop", IF_ID_instr, 32'h0000_0000);
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back('{instr: exp_pc + ofs, pc4: exp_pc + 32'd4});
      @(negedge clock);
      chk("stream_req", {31'd0, mem.imem_req}, 32'd1);
      chk("stream_addr", mem.imem_addr, exp_pc);
      cyc();
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  // Redirect in a 0-wait fetch cycle: the word at exp_pc is dropped.
  task automatic redir(input bit br, input bit jp, input logic [31:0] bt, input logic [31:0] jt);
    branch_taken = br; branch_target = bt; jump = jp; jump_target = jt;
    @(negedge clock);
    chk("redir_addr", mem.imem_addr, exp_pc);
    cyc();
    branch_taken = 1'b0; jump = 1'b0;
    exp_pc = br ? bt : jt;
  endtask

  task automatic do_reset();
    reset = 1'b1; ack_en = 1'b0;
    @(negedge clock);
    chk("rst_req", {31'd0, mem.imem_req}, 32'd0);
    cyc();
    chk("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
    chk("rst_instr", IF_ID_instr, 32'h0000_0000);
    chk("rst_pc4", IF_ID_PCplus4, 32'h0000_0000);
    chk("rst_addr", mem.imem_addr, 32'h0000_0000);
    reset = 1'b0; ack_en = 1'b1;
    exp_pc = 32'h0000_0000;
  endtask

  // Fetch at exp_pc stays unacked while redirecting; optional overwrite and same-cycle redirect.
  task automatic drain(input logic [31:0] ta, input bit bb, input logic [31:0] tbb,
                       input bit bc, input logic [31:0] tc, input logic [31:0] expt);
    logic [31:0] old;
    old = exp_pc;
    ack_en = 1'b0; branch_taken = 1'b1; branch_target = ta;
    @(negedge clock);
    chk("drain_a_addr", mem.imem_addr, old);
    cyc();
    branch_taken = bb; branch_target = tbb;
    @(negedge clock);
    chk("drain_b_req", {31'd0, mem.imem_req}, 32'd1);
    chk("drain_b_addr", mem.imem_addr, old);
    chk("drain_b_valid", {31'd0, IF_ID_valid}, 32'd0);
    cyc();
    ack_en = 1'b1; branch_taken = bc; branch_target = tc;
    @(negedge clock);
    chk("drain_c_addr", mem.imem_addr, old);
    chk("drain_c_valid", {31'd0, IF_ID_valid}, 32'd0);
    cyc();
    branch_taken = 1'b0;
    exp_pc = expt;
  endtask

  vec_t vec[4];

  initial begin
    logic [31:0] p;
    vec[0] = '{jp: 1'b0, tgt: 32'h0000_0100, ofs: 32'h1000_0000, n: 3, next: 32'h0000_010C};
    vec[1] = '{jp: 1'b0, tgt: 32'hFFFF_FFF8, ofs: 32'h2000_0000, n: 4, next: 32'h0000_0008};
    vec[2] = '{jp: 1'b1, tgt: 32'h0000_0200, ofs: 32'h0000_0003, n: 2, next: 32'h0000_0208};
    vec[3] = '{jp: 1'b0, tgt: 32'h0000_0002, ofs: 32'h0000_0000, n: 2, next: 32'h0000_000A};

    reset = 1'b1; PCWrite = 1'b1; IFID_Write = 1'b1; branch_taken = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0; ack_en = 1'b0; ofs = '0; exp_pc = '0;
    cyc();
    do_reset();

    // T1: 0-wait streaming, instr == PC.
    stream(6);

    // Redirect table, including wrap past 32'hFFFF_FFFC and an unaligned target.
    for (int k = 0; k < 4; k++) begin
      ofs = vec[k].ofs;
      redir(!vec[k].jp, vec[k].jp, vec[k].tgt, vec[k].tgt);
      stream(vec[k].n);
      exp_pc = vec[k].next;
    end

    // T2: ack two cycles late at 0x10.
    ofs = 32'h0500_0000;
    redir(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    ack_en = 1'b0;
    @(negedge clock); chk("t2_addr_a", mem.imem_addr, 32'h10);
    cyc();
    @(negedge clock); chk("t2_addr_b", mem.imem_addr, 32'h10);
    chk("t2_valid_b", {31'd0, IF_ID_valid}, 32'd0);
    cyc();
    ack_en = 1'b1;
    sb.push_back('{instr: 32'h10 + ofs, pc4: 32'h14});
    @(negedge clock); chk("t2_addr_c", mem.imem_addr, 32'h10);
    chk("t2_valid_c", {31'd0, IF_ID_valid}, 32'd0);
    cyc();
    exp_pc = 32'h14;
    stream(2);

    // T3: stall across the ack; the jump issued during the stall must be ignored.
    p = exp_pc;
    IFID_Write = 1'b0;
    sb.push_back('{instr: p + ofs, pc4: p + 32'd4});
    @(negedge clock); chk("t3_addr", mem.imem_addr, p);
    cyc();
    PCWrite = 1'b0; IFID_Write = 1'b1; jump = 1'b1; jump_target = 32'h40;
    @(negedge clock); chk("t3_req_1", {31'd0, mem.imem_req}, 32'd0);
    chk("t3_frozen_1", IF_ID_PCplus4, p);
    cyc();
    IFID_Write = 1'b0; jump = 1'b0;
    @(negedge clock); chk("t3_req_2", {31'd0, mem.imem_req}, 32'd0);
    chk("t3_frozen_2", IF_ID_PCplus4, p);
    cyc();
    PCWrite = 1'b1; IFID_Write = 1'b1;
    @(negedge clock); chk("t3_req_3", {31'd0, mem.imem_req}, 32'd0);
    cyc();
    exp_pc = p + 32'd4;
    stream(2);

    // T4: redirect while the fetch at 0x20 is pending, then pending-overwrite and same-cycle variants.
    ofs = 32'h0600_0000;
    redir(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    drain(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100);
    stream(3);
    drain(32'h300, 1'b1, 32'h380, 1'b0, 32'h0, 32'h380);
    stream(2);
    drain(32'h500, 1'b0, 32'h0, 1'b1, 32'h5C0, 32'h5C0);
    stream(2);

    // T5: branch beats jump in the same cycle.
    redir(1'b1, 1'b1, 32'h0000_0080, 32'h0000_0040);
    stream(2);

    // T6: reset while draining a wrong-path fetch.
    ack_en = 1'b0; branch_taken = 1'b1; branch_target = 32'h900;
    @(negedge clock); chk("t6_addr", mem.imem_addr, exp_pc);
    cyc();
    branch_taken = 1'b0;
    @(negedge clock); chk("t6_drain_req", {31'd0, mem.imem_req}, 32'd1);
    cyc();
    do_reset();
    ofs = 32'h0700_0000;
    stream(3);
    ack_en = 1'b0;
    @(negedge clock);
    #1;
    chk("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
